// File: rtl/ram_arbiter_2m.sv
// Two-master arbiter in front of the single-port 2Kx32 RAM. Each access takes a
// fixed IDLE -> ISSUE -> DONE schedule that matches the RAM's registered read.
module ram_arbiter_2m #(
    parameter int ADDR_W     = 11,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_valid,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,
    input  logic              m1_valid,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_we,
    output logic              ram_en,
    input  logic [31:0]       ram_rdata,
    output logic              grant,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t state, state_nxt;
    logic   grant_nxt;
    logic   last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;   // master 0 wins the first tie
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            if (state == DONE) last <= grant;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_nxt = ISSUE;
                    if (m0_valid && m1_valid)
                        grant_nxt = (FIXED_PRIO != 0) ? 1'b0 : ~last;
                    else
                        grant_nxt = m1_valid;
                end
            end
            ISSUE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Everything below decodes from registered state/grant only; reset gates
    // the strobes so a reset in ISSUE blocks the write and one in DONE hides ready.
    logic [31:0] sel_addr;
    assign sel_addr  = grant ? m1_addr  : m0_addr;
    assign ram_addr  = sel_addr[ADDR_W+1:2];
    assign ram_wdata = grant ? m1_wdata : m0_wdata;
    assign ram_en    = (state == ISSUE) && !reset;
    assign ram_we    = ram_en ? (grant ? m1_wstrb : m0_wstrb) : 4'b0000;
    assign m0_ready  = (state == DONE) && !grant && !reset;
    assign m1_ready  = (state == DONE) &&  grant && !reset;
    assign m0_rdata  = ram_rdata;
    assign m1_rdata  = ram_rdata;
    assign busy      = (state != IDLE) && !reset;

    // Byte-offset and out-of-window address bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};
endmodule

// File: tb/tb_ram_arbiter_2m.sv
// Directed bench: a round-robin instance (a) and a fixed-priority instance (b)
// share master stimulus, each with its own behavioural registered-read RAM.
module tb_ram_arbiter_2m;
    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;

    logic        m0_ready_a, m1_ready_a, ram_en_a, grant_a, busy_a;
    logic [31:0] m0_rdata_a, m1_rdata_a, ram_wdata_a, rdata_a;
    logic [10:0] ram_addr_a;
    logic [3:0]  ram_we_a;
    logic        m0_ready_b, m1_ready_b, ram_en_b, grant_b, busy_b;
    logic [31:0] m0_rdata_b, m1_rdata_b, ram_wdata_b, rdata_b;
    logic [10:0] ram_addr_b;
    logic [3:0]  ram_we_b;

    logic        pl_en = 1'b0;
    logic [10:0] pl_addr = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] mem_a [0:2047];
    logic [31:0] mem_b [0:2047];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ram_arbiter_2m #(.ADDR_W(11), .FIXED_PRIO(0)) dut_a (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready_a), .m0_rdata(m0_rdata_a),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready_a), .m1_rdata(m1_rdata_a),
        .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a), .ram_we(ram_we_a), .ram_en(ram_en_a),
        .ram_rdata(rdata_a), .grant(grant_a), .busy(busy_a)
    );

    ram_arbiter_2m #(.ADDR_W(11), .FIXED_PRIO(1)) dut_b (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready_b), .m0_rdata(m0_rdata_b),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready_b), .m1_rdata(m1_rdata_b),
        .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_we(ram_we_b), .ram_en(ram_en_b),
        .ram_rdata(rdata_b), .grant(grant_b), .busy(busy_b)
    );

    // Registered-read RAMs (read returns the old word on a write) with a preload port.
    always @(posedge clk) begin
        if (pl_en) begin
            mem_a[pl_addr] <= pl_data;
            mem_b[pl_addr] <= pl_data;
        end else begin
            if (ram_en_a) begin
                for (int b = 0; b < 4; b++)
                    if (ram_we_a[b]) mem_a[ram_addr_a][8*b +: 8] <= ram_wdata_a[8*b +: 8];
                rdata_a <= mem_a[ram_addr_a];
            end
            if (ram_en_b) begin
                for (int b = 0; b < 4; b++)
                    if (ram_we_b[b]) mem_b[ram_addr_b][8*b +: 8] <= ram_wdata_b[8*b +: 8];
                rdata_b <= mem_b[ram_addr_b];
            end
        end
    end

    task automatic preload(input logic [10:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m0_valid = 1'b0; m1_valid = 1'b0;
        m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m0_valid = 1'b1; m1_valid = 1'b1;
        repeat (2) @(negedge clk);
        nvec++;
        if ({ram_en_a, ram_we_a, m0_ready_a, m1_ready_a, busy_a, grant_a} !== 9'b0) begin
            nerr++;
            $display("FAIL reset_outputs: got en=%b we=%b r0=%b r1=%b busy=%b grant=%b, need all 0",
                     ram_en_a, ram_we_a, m0_ready_a, m1_ready_a, busy_a, grant_a);
        end
        do_reset();
    endtask

    task automatic test_m0_read();
        do_reset();
        preload(11'h010, 32'hDEADBEEF);
        m0_valid = 1'b1; m0_addr = 32'h0000_0040; m0_wstrb = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            nvec++;
            if (ram_en_a !== (k == 1) || m0_ready_a !== (k == 2) || m1_ready_a !== 1'b0 || ram_we_a !== 4'b0) begin
                nerr++;
                $display("FAIL m0_read_cycle%0d: got en=%b r0=%b r1=%b we=%b, need en=%b r0=%b r1=0 we=0",
                         k, ram_en_a, m0_ready_a, m1_ready_a, ram_we_a, k == 1, k == 2);
            end
            if (k == 1) begin
                nvec++;
                if (ram_addr_a !== 11'h010) begin
                    nerr++;
                    $display("FAIL m0_read_addr: got %h, need 010", ram_addr_a);
                end
            end
            if (k == 2) begin
                nvec++;
                if (m0_rdata_a !== 32'hDEADBEEF) begin
                    nerr++;
                    $display("FAIL m0_read_data: got %h, need deadbeef", m0_rdata_a);
                end
                m0_valid = 1'b0;
            end
        end
    endtask

    task automatic test_m1_byte_write();
        do_reset();
        preload(11'h011, 32'h12345678);
        m1_valid = 1'b1; m1_addr = 32'h0000_0044; m1_wdata = 32'h0000_00AB; m1_wstrb = 4'b0001;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            nvec++;
            if (ram_we_a !== ((k == 1) ? 4'b0001 : 4'b0000) || m1_ready_a !== (k == 2) || m0_ready_a !== 1'b0) begin
                nerr++;
                $display("FAIL m1_write_cycle%0d: got we=%b r1=%b r0=%b", k, ram_we_a, m1_ready_a, m0_ready_a);
            end
            if (k == 1) begin
                nvec++;
                if (ram_addr_a !== 11'h011 || grant_a !== 1'b1) begin
                    nerr++;
                    $display("FAIL m1_write_addr: got addr=%h grant=%b, need 011 and 1", ram_addr_a, grant_a);
                end
            end
            if (k == 2) m1_valid = 1'b0;
        end
        // Read back through an alias: high bits and byte offset must be ignored.
        m1_valid = 1'b1; m1_addr = 32'h8000_0046; m1_wstrb = 4'b0000;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 2) begin
                nvec++;
                if (m1_ready_a !== 1'b1 || m1_rdata_a !== 32'h123456AB) begin
                    nerr++;
                    $display("FAIL m1_readback: got ready=%b data=%h, need 1 and 123456ab", m1_ready_a, m1_rdata_a);
                end
                m1_valid = 1'b0;
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        m0_valid = 1'b1; m1_valid = 1'b1; m0_wstrb = '0; m1_wstrb = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            nvec++;
            if (m0_ready_a !== (k == 2 || k == 8) || m1_ready_a !== (k == 5 || k == 11)) begin
                nerr++;
                $display("FAIL rr_cycle%0d: got r0=%b r1=%b, need r0=%b r1=%b",
                         k, m0_ready_a, m1_ready_a, k == 2 || k == 8, k == 5 || k == 11);
            end
            if (k == 1 || k == 4) begin
                nvec++;
                if (grant_a !== (k == 4) || busy_a !== 1'b1) begin
                    nerr++;
                    $display("FAIL rr_grant%0d: got grant=%b busy=%b, need grant=%b busy=1", k, grant_a, busy_a, k == 4);
                end
            end
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
    endtask

    task automatic test_fixed_prio();
        do_reset();
        m0_valid = 1'b1; m1_valid = 1'b1; m0_wstrb = '0; m1_wstrb = '0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            nvec++;
            if (m0_ready_b !== (k == 2 || k == 5 || k == 8) || m1_ready_b !== (k == 11)) begin
                nerr++;
                $display("FAIL fixed_cycle%0d: got r0=%b r1=%b, need r0=%b r1=%b",
                         k, m0_ready_b, m1_ready_b, k == 2 || k == 5 || k == 8, k == 11);
            end
            if (k == 8)  m0_valid = 1'b0;
            if (k == 11) m1_valid = 1'b0;
        end
    endtask

    task automatic test_reset_in_issue();
        do_reset();
        preload(11'h005, 32'h0000_0000);
        m0_valid = 1'b1; m0_addr = 32'h0000_0014; m0_wdata = 32'hFFFFFFFF; m0_wstrb = 4'b1111;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        nvec++;
        if (ram_we_a !== 4'b0 || ram_en_a !== 1'b0 || m0_ready_a !== 1'b0 || busy_a !== 1'b0) begin
            nerr++;
            $display("FAIL reset_issue_gate: got we=%b en=%b r0=%b busy=%b, need all 0",
                     ram_we_a, ram_en_a, m0_ready_a, busy_a);
        end
        m0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            nvec++;
            if (busy_a !== 1'b0 || m0_ready_a !== 1'b0) begin
                nerr++;
                $display("FAIL reset_issue_idle%0d: got busy=%b r0=%b, need 0 0", k, busy_a, m0_ready_a);
            end
        end
        m0_valid = 1'b1; m0_wstrb = 4'b0000;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 2) begin
                nvec++;
                if (m0_ready_a !== 1'b1 || m0_rdata_a !== 32'h0) begin
                    nerr++;
                    $display("FAIL reset_issue_word5: got ready=%b data=%h, need 1 and 00000000", m0_ready_a, m0_rdata_a);
                end
                m0_valid = 1'b0;
            end
        end
    endtask

    task automatic test_idle_quiet();
        do_reset();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            nvec++;
            if ({ram_en_a, busy_a, m0_ready_a, m1_ready_a, ram_en_b, busy_b, m0_ready_b, m1_ready_b} !== 8'b0) begin
                nerr++;
                $display("FAIL idle_quiet%0d: got a{en,busy,r0,r1}=%b%b%b%b b=%b%b%b%b, need 0",
                         k, ram_en_a, busy_a, m0_ready_a, m1_ready_a, ram_en_b, busy_b, m0_ready_b, m1_ready_b);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        m0_valid = 1'b0; m1_valid = 1'b0;
        m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        test_reset();
        test_m0_read();
        test_m1_byte_write();
        test_round_robin();
        test_fixed_prio();
        test_reset_in_issue();
        test_idle_quiet();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/ram_arbiter_2m.md
# ram_arbiter_2m

Two-master arbiter sharing the single-port 2K×32 on-chip RAM between the picorv32 core (master 0) and a second bus master (master 1, e.g. UART boot loader or DMA). Both masters use the core's native valid/ready memory handshake. The arbiter sequences each access through a fixed three-state schedule that matches the RAM's one-cycle registered-read latency. It sits between the core/loader and `ram_2k_32`, replacing the direct core-to-RAM hookup in the top level.

## Interface
Parameters:
- `ADDR_W`, default 11: RAM word-address width; the RAM index is byte address bits [ADDR_W+1:2].
- `FIXED_PRIO`, default 0: 0 selects round-robin; 1 means master 0 always wins contention.

Ports:
- `clk` in 1: system clock; the single clock for the block.
- `reset` in 1: synchronous, active-high reset.
- `m0_valid` in 1: master 0 request.
- `m0_addr` in 32: master 0 byte address.
- `m0_wdata` in 32: master 0 write data.
- `m0_wstrb` in 4: master 0 byte write enables; 0 means read.
- `m0_ready` out 1: master 0 transfer complete; one-cycle pulse.
- `m0_rdata` out 32: master 0 read data; valid only while `m0_ready` is high.
- `m1_valid`, `m1_addr`, `m1_wdata`, `m1_wstrb`, `m1_ready`, `m1_rdata`: same as master 0, for master 1.
- `ram_addr` out ADDR_W: RAM word address.
- `ram_wdata` out 32: RAM write data.
- `ram_we` out 4: RAM byte write enables.
- `ram_en` out 1: RAM enable.
- `ram_rdata` in 32: RAM read data; valid the cycle after `ram_en`.
- `grant` out 1: index of the master currently owned/served.
- `busy` out 1: high when the state is not IDLE.

## Operation
FSM states: IDLE, ISSUE, DONE.

- **IDLE**
  - If any `mX_valid` is high, pick a winner, register it in `grant`, and go to ISSUE.
  - Otherwise stay in IDLE.
- **Winner selection**
  - Only one master valid: that master wins.
  - Both valid, `FIXED_PRIO=1`: master 0 wins.
  - Both valid, `FIXED_PRIO=0`: the master not recorded in `last` wins.
- **ISSUE**
  - `ram_en`=1.
  - `ram_addr` = granted master's addr[ADDR_W+1:2].
  - `ram_wdata` and `ram_we` come from the granted master's wdata and wstrb.
  - Go to DONE.
- **DONE**
  - `m<grant>_ready`=1 and `m<grant>_rdata` = `ram_rdata`.
  - Update `last` <= `grant`, then go to IDLE.
  - On writes, `rdata` carries the old word and is don't-care to masters.
- **Output drive rules**
  - RAM outputs and ready signals are decoded from the registered state/grant. They never depend on the valid inputs in the same cycle.
  - `ram_we`=0 and `ram_en`=0 in every state other than ISSUE.
  - `ram_addr`/`ram_wdata` hold the granted master's values outside ISSUE as well; they are don't-care there.
  - The non-granted master's `ready` stays 0.
  - `mX_rdata` may mirror `ram_rdata` at all times; it is qualified by `ready`.
- **Address handling**
  - Address bits above ADDR_W+1 and bits [1:0] are ignored; no range check.
  - Decoding the RAM region is the top level's job.
- **Master obligations**
  - Masters hold valid/addr/wdata/wstrb stable from assertion until their `ready` pulse.
  - A valid seen in IDLE (including the cycle after `ready`) is a new request.
  - A request is never dropped; a waiting master keeps valid high.
- **Reset**
  - State=IDLE, `grant`=0, `last`=1, so master 0 wins the first tie.
  - While `reset` is high: `ram_en`=0, `ram_we`=0, `m0_ready`=`m1_ready`=0, `busy`=0, regardless of state.
  - Reset in ISSUE therefore blocks the write; reset in DONE suppresses `ready`. The master re-issues after reset.

## Timing
- Per access: 3 cycles from valid seen in IDLE (cycle 0), through `ram_en` (cycle 1), to `ready` (cycle 2).
- Next grant is possible at cycle 3; peak throughput is one access per 3 cycles.
- Contention latency: worst case 6 cycles for the losing master in round-robin mode.
- Starvation: unbounded for master 1 when `FIXED_PRIO=1` and master 0 requests continuously; this is intended.
- Simultaneous new request while another is in flight: it waits; it is arbitrated in the next IDLE.
- `busy` is 1 in ISSUE and DONE, and 0 in IDLE.

## Test plan
- **Master 0 read.** Preload RAM word 0x10 = 0xDEADBEEF; m0 read of byte address 0x40. Required: `ram_en` high exactly on cycle 1 with `ram_addr`=0x10 and `ram_we`=0; `m0_ready` high for exactly 1 cycle on cycle 2 with `m0_rdata`=0xDEADBEEF; `m1_ready` stays 0.
- **Master 1 byte write.** m1 writes 0x000000AB to address 0x44 with `wstrb`=4'b0001 over word 0x12345678. Required: `ram_we`=4'b0001 only in ISSUE; a following read returns 0x123456AB.
- **Round-robin contention.** `FIXED_PRIO=0`, both masters request continuously from reset. Required: grant order 0,1,0,1; each `ready` is spaced 3 cycles apart; no master is served twice in a row.
- **Fixed priority.** `FIXED_PRIO=1`, m0 issues back-to-back requests while m1 holds valid. Required: m1 gets no `ready` until m0 drops valid; then m1 completes 3 cycles later.
- **Reset in ISSUE.** Assert `reset` during the ISSUE cycle of an m0 write of 0xFFFFFFFF to word 5 (old value 0). Required: `ram_we`=0 on that cycle, word 5 stays 0, no `ready`, and state is IDLE after reset.
- **Idle quiet.** No valids for 100 cycles. Required: `ram_en`=0, `busy`=0, both `ready`=0 throughout.
